f2sdram_arbiter: RTL
====================

Name: f2sdram_arbiter

Overview:
- Parametrised N-channel Avalon-MM arbiter. Shares one HPS f2sdram port among NUM_CH core masters, so a core can use more DDR clients than the fixed three-port configuration allows.
- Sits between the core masters and one sysmem f2sdram port.
- Adds round-robin arbitration, write-burst locking, read-return routing through a tag FIFO, and a programmable power-up hold-off.

Parameters:
- NUM_CH, 3, number of upstream master channels (1..8).
- AW, 29, word address width.
- DW, 64, data width.
- BCW, 8, burstcount width.
- TAG_DEPTH, 16, maximum outstanding read bursts (power of 2).
- INIT_CYCLES, 2000000, cycles after reset during which no command is issued.

Ports:
- clk  in  1  system clock (all ports synchronous).
- reset  in  1  synchronous active-high reset.
- ch_address  in  NUM_CH*AW  per-channel address; channel i occupies slice [i*AW +: AW].
- ch_burstcount  in  NUM_CH*BCW  per-channel burst length.
- ch_read  in  NUM_CH  read request.
- ch_write  in  NUM_CH  write request.
- ch_writedata  in  NUM_CH*DW  write data.
- ch_byteenable  in  NUM_CH*DW/8  byte enables.
- ch_waitrequest  out  NUM_CH  per-channel stall.
- ch_readdata  out  DW  read data, broadcast to all channels.
- ch_readdatavalid  out  NUM_CH  one-hot read-valid for the owning channel.
- m_address  out  AW  downstream command address.
- m_burstcount  out  BCW  downstream burst length.
- m_read  out  1  downstream read.
- m_write  out  1  downstream write.
- m_writedata  out  DW  downstream write data.
- m_byteenable  out  DW/8  downstream byte enables.
- m_waitrequest  in  1  downstream stall.
- m_readdata  in  DW  downstream read data.
- m_readdatavalid  in  1  downstream read-valid.
- init_done  out  1  high once the hold-off has expired.
- err_orphan  out  1  sticky: read-valid arrived with no outstanding read.

Behaviour:
- **Reset values:** all ch_waitrequest=1, ch_readdatavalid=0, m_read=0, m_write=0, init_done=0, err_orphan=0. Reset flushes the tag FIFO, the beat counters, the lock and the RR pointer (pointer=0). Reset in the middle of a burst aborts it silently.
- **Hold-off:** a counter runs from 0 to INIT_CYCLES-1, then init_done=1 and stays high until the next reset. While init_done=0, all ch_waitrequest=1 and no command is issued.
- **Command register:** holds one registered command (m_*).
  - It is free when m_read=m_write=0, or when m_waitrequest=0 in the current cycle.
  - Otherwise all m_* hold stable.
- **Accept:** in a cycle where the register is free and a channel wins, ch_waitrequest[win]=0 (combinational) and the request loads into the register at the clock edge. The command therefore appears on m_* one cycle after acceptance. Every other channel sees ch_waitrequest=1.
- **FSM states:**
  - IDLE: arbitrate.
    - Winner has ch_read: accept, push {ch, burstcount} to the tag FIFO, stay in IDLE.
    - Winner has ch_write with burstcount>1: accept the first beat, set beats_left=burstcount-1, go to WLOCK.
    - Winner has ch_write with burstcount<=1: accept, stay in IDLE.
  - WLOCK: only the locked channel may be accepted, and only when ch_write is asserted. Each accepted beat decrements beats_left; at 0, return to IDLE. Other channels stay stalled for the whole burst.
- **Arbitration:** round-robin, search order pointer, pointer+1, … mod NUM_CH. After each first-beat accept, pointer = win+1 mod NUM_CH.
- **Read gating:** when the tag FIFO is full (TAG_DEPTH entries), read requests are not eligible. Writes remain eligible.
- **Burstcount 0** is treated as 1 everywhere.
- **Read and write asserted together** on one channel: illegal; the write wins and a simulation assertion fires.
- **Read return:**
  - ch_readdata = m_readdata, registered with 1-cycle latency.
  - ch_readdatavalid[head.ch] = registered m_readdatavalid.
  - A return-beat counter loads head.burstcount; the FIFO entry pops on the last beat.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
- **Orphan beat:** m_readdatavalid while the FIFO is empty is dropped (no ch_readdatavalid) and sets err_orphan. This covers in-flight data arriving after a reset.
- **Ordering:** read returns follow issue order. Writes and reads from different channels are not ordered against each other.

Test Plan:
- **Hold-off (INIT_CYCLES=8):** reset, then ch0 read held high → ch_waitrequest[0]=1 and m_read=0 for 8 cycles; init_done rises at cycle 8; m_read=1 with the ch0 address one cycle after accept.
- **Round-robin:** NUM_CH=3, all channels issue continuous single reads with m_waitrequest=0 → grant order 0,1,2,0,1,2; each read is returned with a 2-beat delay; each readdatavalid reaches only its issuer.
- **Write lock:** ch1 issues a 4-beat write while ch0 and ch2 request → 4 consecutive m_write beats from ch1 with correct data/byteenable, no interleaving; the next grant goes to ch2.
- **Backpressure:** m_waitrequest high for 5 cycles during a ch2 read → m_* held stable, all ch_waitrequest=1; issue proceeds after m_waitrequest drops.
- **FIFO full:** TAG_DEPTH=4, four ch0 burst-8 reads with returns stalled → a fifth read stays stalled while a ch1 write is still accepted; once the first 8 beats return, the read is accepted.
- **Reset mid-read:** reset asserted with 2 beats still outstanding, then 2 m_readdatavalid pulses → no ch_readdatavalid, err_orphan=1.

Source files
------------

// File: rtl/f2sdram_arbiter.sv
// f2sdram_arbiter: shares one f2sdram Avalon-MM port among NUM_CH masters.
// Round-robin arbitration, write-burst locking, in-order read-return routing
// through a tag FIFO, and a power-up hold-off before any command is issued.
module f2sdram_arbiter #(
    parameter int NUM_CH      = 3,
    parameter int AW          = 29,
    parameter int DW          = 64,
    parameter int BCW         = 8,
    parameter int TAG_DEPTH   = 16,
    parameter int INIT_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CH*AW-1:0]   ch_address,
    input  logic [NUM_CH*BCW-1:0]  ch_burstcount,
    input  logic [NUM_CH-1:0]      ch_read,
    input  logic [NUM_CH-1:0]      ch_write,
    input  logic [NUM_CH*DW-1:0]   ch_writedata,
    input  logic [NUM_CH*DW/8-1:0] ch_byteenable,
    output logic [NUM_CH-1:0]      ch_waitrequest,
    output logic [DW-1:0]          ch_readdata,
    output logic [NUM_CH-1:0]      ch_readdatavalid,
    output logic [AW-1:0]          m_address,
    output logic [BCW-1:0]         m_burstcount,
    output logic                   m_read,
    output logic                   m_write,
    output logic [DW-1:0]          m_writedata,
    output logic [DW/8-1:0]        m_byteenable,
    input  logic                   m_waitrequest,
    input  logic [DW-1:0]          m_readdata,
    input  logic                   m_readdatavalid,
    output logic                   init_done,
    output logic                   err_orphan
);

    localparam int unsigned NCH = NUM_CH;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int BEW = DW / 8;

    typedef enum logic {IDLE, WLOCK} state_t;

    state_t           state, state_nxt;
    logic [BCW-1:0]   beats_left, beats_left_nxt;
    logic [CW-1:0]    lock_ch, lock_ch_nxt;
    logic [CW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [31:0]      init_cnt;

    logic [NUM_CH-1:0] eligible;
    logic [CW-1:0]     win;
    logic              win_found;
    logic              cmd_free;
    logic              accept;
    logic [AW-1:0]     sel_addr;
    logic [BCW-1:0]    sel_bc;
    logic [DW-1:0]     sel_data;
    logic [BEW-1:0]    sel_be;
    logic              sel_write;

    logic [CW+BCW-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0]     tag_wr_ptr, tag_rd_ptr;
    logic [PW:0]       tag_count;
    logic              tag_full, tag_empty, tag_push, tag_pop;
    logic [CW-1:0]     head_ch;
    logic [BCW-1:0]    head_bc;
    logic [BCW-1:0]    ret_left, ret_cur;

    // Power-up hold-off counter; init_done stays high until the next reset
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            if (init_cnt == 32'(INIT_CYCLES - 1)) init_done <= 1'b1;
            else                                   init_cnt  <= init_cnt + 32'd1;
        end
    end

    // Per-channel eligibility: only the locked writer during a burst
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (state == WLOCK) eligible[i] = (CW'(i) == lock_ch) && ch_write[i];
            else                eligible[i] = ch_write[i] || (ch_read[i] && !tag_full);
        end
    end

    // Round-robin search starting at rr_ptr, plus winner field mux
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win       = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(rr_ptr) + k) % NCH;
            if (!win_found && eligible[CW'(idx)]) begin
                win       = CW'(idx);
                win_found = 1'b1;
            end
        end
        sel_addr  = '0;
        sel_bc    = '0;
        sel_data  = '0;
        sel_be    = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (CW'(i) == win) begin
                sel_addr  = ch_address[i*AW +: AW];
                sel_bc    = ch_burstcount[i*BCW +: BCW];
                sel_data  = ch_writedata[i*DW +: DW];
                sel_be    = ch_byteenable[i*BEW +: BEW];
                sel_write = ch_write[i];
            end
        end
        // Burstcount 0 behaves as a single beat
        if (sel_bc == '0) sel_bc = BCW'(1);
    end

    assign cmd_free = !(m_read || m_write) || !m_waitrequest;
    assign accept   = init_done && cmd_free && win_found;

    // Combinational stall: only the accepted channel sees waitrequest low
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++)
            ch_waitrequest[i] = !(accept && (win == CW'(i)));
    end

    // FSM next-state, lock bookkeeping and RR pointer update
    always_comb begin
        state_nxt      = state;
        beats_left_nxt = beats_left;
        lock_ch_nxt    = lock_ch;
        rr_ptr_nxt     = rr_ptr;
        tag_push       = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    rr_ptr_nxt = (win == CW'(NCH - 1)) ? '0 : win + CW'(1);
                    if (sel_write) begin
                        if (sel_bc > BCW'(1)) begin
                            state_nxt      = WLOCK;
                            beats_left_nxt = sel_bc - BCW'(1);
                            lock_ch_nxt    = win;
                        end
                    end else begin
                        tag_push = 1'b1;
                    end
                end
                WLOCK: begin
                    beats_left_nxt = beats_left - BCW'(1);
                    if (beats_left == BCW'(1)) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beats_left <= '0;
            lock_ch    <= '0;
            rr_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_left_nxt;
            lock_ch    <= lock_ch_nxt;
            rr_ptr     <= rr_ptr_nxt;
        end
    end

    // Downstream command register: load on accept, clear once consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            m_address    <= '0;
            m_burstcount <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_writedata  <= '0;
            m_byteenable <= '0;
        end else if (accept) begin
            m_address    <= sel_addr;
            m_burstcount <= sel_bc;
            m_read       <= !sel_write;
            m_write      <= sel_write;
            m_writedata  <= sel_data;
            m_byteenable <= sel_be;
        end else if (cmd_free) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
        end
    end

    // Tag FIFO storage (contents need no reset; pointers qualify them)
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr_ptr] <= {win, sel_bc};
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + PW'(1);
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + PW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + (PW+1)'(1);
                2'b01:   tag_count <= tag_count - (PW+1)'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    assign tag_full  = (tag_count == (PW+1)'(TAG_DEPTH));
    assign tag_empty = (tag_count == '0);
    assign {head_ch, head_bc} = tag_mem[tag_rd_ptr];

    // ret_left == 0 means the head entry has not started returning yet
    assign ret_cur = (ret_left == '0) ? head_bc : ret_left;
    assign tag_pop = m_readdatavalid && !tag_empty && (ret_cur == BCW'(1));

    // Read-return routing to the owning channel; unmatched beats are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_readdata      <= '0;
            ch_readdatavalid <= '0;
            ret_left         <= '0;
            err_orphan       <= 1'b0;
        end else begin
            ch_readdata      <= m_readdata;
            ch_readdatavalid <= '0;
            if (m_readdatavalid) begin
                if (tag_empty) begin
                    err_orphan <= 1'b1;
                end else begin
                    ch_readdatavalid[head_ch] <= 1'b1;
                    ret_left <= tag_pop ? '0 : ret_cur - BCW'(1);
                end
            end
        end
    end

    // Read and write together on one channel is illegal (write takes priority)
    always_ff @(posedge clk) begin
        if (!reset) assert ((ch_read & ch_write) == '0);
    end

endmodule
